// File: rtl/switch_pkg.sv
// switch_pkg: shared FSM state type and default parameters for the switch receive port
package switch_pkg;
    typedef enum logic [1:0] {IDLE, HDR_SA, PAYLOAD, DISCARD} state_t;
    localparam int DATA_W_DEF    = 8;
    localparam int DEPTH_DEF     = 16;
    localparam int NUM_PORTS_DEF = 4;
    localparam int AF_THRESH_DEF = 4;
    localparam int CNT_W_DEF     = 16;
endpackage

// File: rtl/switch_sync_fifo.sv
// switch_sync_fifo: first-word-fall-through FIFO that exports its occupancy
module switch_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_wr, do_rd;
    assign valid   = count != '0;
    assign do_rd   = rd_en && valid;
    assign do_wr   = wr_en && (count != (AW+1)'(DEPTH) || do_rd);
    assign rd_data = mem[rd_ptr];
    // storage array: only accepted writes land, contents need no reset
    always_ff @(posedge clk)
        if (do_wr) mem[wr_ptr] <= wr_data;
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            if (do_wr != do_rd) count <= do_wr ? count + 1'b1 : count - 1'b1;
        end
endmodule

// File: rtl/switch_rx_port.sv
// switch_rx_port: frames serial packet bytes into a tagged FIFO with admission, truncation and stats
module switch_rx_port
    import switch_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int AF_THRESH = AF_THRESH_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DATA_W-1:0]            data_in,
    input  logic                         sw_enable_in,
    output logic                         read_out,
    output logic                         pkt_valid,
    input  logic                         pkt_ready,
    output logic [DATA_W-1:0]            pkt_data,
    output logic                         pkt_sop,
    output logic                         pkt_eop,
    output logic                         pkt_err,
    output logic [$clog2(NUM_PORTS)-1:0] pkt_dst,
    output logic [CNT_W-1:0]             drop_cnt,
    output logic [CNT_W-1:0]             runt_cnt,
    output logic [CNT_W-1:0]             trunc_cnt
);
    localparam int DST_W = $clog2(NUM_PORTS);
    localparam int AW    = $clog2(DEPTH);
    localparam int EW    = DATA_W + 3 + DST_W;

    state_t            state, state_d;
    logic [DATA_W-1:0] hold;
    logic              hold_sop, long_pkt;
    logic [DST_W-1:0]  dst;
    logic [AW:0]       count, free;
    logic              wr, wr_eop, wr_err, load, shift;
    logic              inc_drop, inc_runt, inc_trunc;
    logic [EW-1:0]     rd_entry;

    assign free     = (AW+1)'(DEPTH) - count;
    assign read_out = free < (AW+1)'(AF_THRESH);

    // state register; reset lands in DISCARD so a packet in flight is never half stored
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= DISCARD;
        else        state <= state_d;

    // next state, FIFO write control and counter events; the byte in hold is written one cycle late
    always_comb begin
        state_d   = state;
        wr        = 1'b0;
        wr_eop    = 1'b0;
        wr_err    = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        inc_drop  = 1'b0;
        inc_runt  = 1'b0;
        inc_trunc = 1'b0;
        case (state)
            IDLE: if (sw_enable_in) begin
                if (data_in >= DATA_W'(NUM_PORTS) || free < (AW+1)'(2)) begin
                    inc_drop = 1'b1;
                    state_d  = DISCARD;
                end else begin
                    load    = 1'b1;
                    state_d = HDR_SA;
                end
            end
            HDR_SA, PAYLOAD: begin
                wr = 1'b1;
                if (!sw_enable_in) begin
                    wr_eop   = 1'b1;
                    wr_err   = state == HDR_SA || !long_pkt;
                    inc_runt = wr_err;
                    state_d  = IDLE;
                end else if (free == (AW+1)'(1)) begin
                    wr_eop    = 1'b1;
                    wr_err    = 1'b1;
                    inc_trunc = 1'b1;
                    state_d   = DISCARD;
                end else begin
                    shift   = 1'b1;
                    state_d = PAYLOAD;
                end
            end
            default: if (!sw_enable_in) state_d = IDLE;
        endcase
    end

    // hold register and per-packet tags; long_pkt marks that a payload byte has been seen
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            hold     <= '0;
            hold_sop <= 1'b0;
            long_pkt <= 1'b0;
            dst      <= '0;
        end else if (load) begin
            hold     <= data_in;
            hold_sop <= 1'b1;
            long_pkt <= 1'b0;
            dst      <= data_in[DST_W-1:0];
        end else if (shift) begin
            hold     <= data_in;
            hold_sop <= 1'b0;
            long_pkt <= state == PAYLOAD;
        end

    // saturating statistics counters
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            drop_cnt  <= '0;
            runt_cnt  <= '0;
            trunc_cnt <= '0;
        end else begin
            if (inc_drop && drop_cnt != '1)   drop_cnt  <= drop_cnt + CNT_W'(1);
            if (inc_runt && runt_cnt != '1)   runt_cnt  <= runt_cnt + CNT_W'(1);
            if (inc_trunc && trunc_cnt != '1) trunc_cnt <= trunc_cnt + CNT_W'(1);
        end

    switch_sync_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr),
        .wr_data ({wr_err, wr_eop, hold_sop, dst, hold}),
        .rd_en   (pkt_ready),
        .rd_data (rd_entry),
        .valid   (pkt_valid),
        .count   (count)
    );

    assign {pkt_err, pkt_eop, pkt_sop, pkt_dst, pkt_data} = rd_entry;
endmodule

// File: tb/tb_switch_rx_port.sv
// tb_switch_rx_port: directed checks of framing, runt/drop/truncation, reset and FIFO boundaries
module tb_switch_rx_port;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  data_in = 8'h00;
    logic        sw_enable_in = 1'b0;
    logic        pkt_ready = 1'b0;
    logic        read_out, pkt_valid, pkt_sop, pkt_eop, pkt_err;
    logic [7:0]  pkt_data;
    logic [1:0]  pkt_dst;
    logic [15:0] drop_cnt, runt_cnt, trunc_cnt;
    int          errors = 0;
    int          checks = 0;

    switch_rx_port dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .sw_enable_in (sw_enable_in),
        .read_out     (read_out),
        .pkt_valid    (pkt_valid),
        .pkt_ready    (pkt_ready),
        .pkt_data     (pkt_data),
        .pkt_sop      (pkt_sop),
        .pkt_eop      (pkt_eop),
        .pkt_err      (pkt_err),
        .pkt_dst      (pkt_dst),
        .drop_cnt     (drop_cnt),
        .runt_cnt     (runt_cnt),
        .trunc_cnt    (trunc_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        data_in = b;
        sw_enable_in = 1'b1;
        step();
    endtask

    task automatic gap();
        sw_enable_in = 1'b0;
        step();
    endtask

    task automatic beat(input string tag, input logic [7:0] d, input logic s, input logic e, input logic r);
        chk(tag, {pkt_valid, pkt_sop, pkt_eop, pkt_err, pkt_data}, {1'b1, s, e, r, d});
    endtask

    task automatic do_reset();
        sw_enable_in = 1'b0;
        pkt_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("reset_state", {pkt_valid, read_out, drop_cnt, runt_cnt, trunc_cnt}, '0);
        rst_n = 1'b1;
        step();
    endtask

    function automatic logic [7:0] pb(input int i);
        return i == 0 ? 8'h00 : 8'(8'h40 + i);
    endfunction

    function automatic logic [7:0] qb(input int i);
        return i == 0 ? 8'h01 : 8'(8'h80 + i);
    endfunction

    initial begin
        #1;
        do_reset();

        pkt_ready = 1'b1;
        send(8'h02);
        chk("r20_empty", pkt_valid, 0);
        send(8'h05);
        beat("r20_b0", 8'h02, 1, 0, 0);
        chk("r20_dst", pkt_dst, 2);
        send(8'hA1);
        beat("r20_b1", 8'h05, 0, 0, 0);
        send(8'hA2);
        beat("r20_b2", 8'hA1, 0, 0, 0);
        gap();
        beat("r20_b3", 8'hA2, 0, 1, 0);
        gap();
        chk("r20_done", {pkt_valid, runt_cnt}, 0);

        send(8'h01);
        send(8'h03);
        beat("r21_b0", 8'h01, 1, 0, 0);
        gap();
        beat("r21_b1", 8'h03, 0, 1, 1);
        chk("r21_runt", runt_cnt, 1);
        gap();
        chk("r21_done", pkt_valid, 0);

        send(8'h03);
        gap();
        beat("one_byte", 8'h03, 1, 1, 1);
        chk("one_byte_dst", pkt_dst, 3);
        chk("one_byte_runt", runt_cnt, 2);
        gap();

        send(8'h07);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        gap();
        chk("r22_empty", pkt_valid, 0);
        chk("r22_drop", drop_cnt, 1);
        send(8'h04);
        send(8'h55);
        send(8'h66);
        gap();
        chk("da4_drop", {pkt_valid, drop_cnt}, 2);

        do_reset();
        for (int i = 0; i < 20; i++) begin
            send(pb(i));
            if (i == 12) chk("r23_ro_occ12", read_out, 0);
            if (i == 13) chk("r23_ro_occ13", read_out, 1);
        end
        gap();
        chk("r23_trunc", {trunc_cnt, runt_cnt}, {16'd1, 16'd0});
        send(8'h01);
        send(8'h02);
        send(8'h03);
        gap();
        chk("r23_drop", drop_cnt, 1);
        chk("r23_full_ro", read_out, 1);
        beat("r23_hold", pb(0), 1, 0, 0);
        pkt_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            beat($sformatf("r23_e%0d", i), pb(i), i == 0, i == 15, i == 15);
            step();
        end
        chk("r23_drained", pkt_valid, 0);

        do_reset();
        send(8'h02);
        send(8'h15);
        data_in = 8'h26;
        rst_n = 1'b0;
        #2;
        chk("r24_async", {pkt_valid, drop_cnt}, 0);
        rst_n = 1'b1;
        step();
        send(8'h37);
        send(8'h48);
        send(8'h59);
        chk("r24_ignored", pkt_valid, 0);
        gap();
        chk("r24_none", {pkt_valid, drop_cnt, runt_cnt}, 0);
        send(8'h03);
        send(8'h0A);
        send(8'h0B);
        gap();
        beat("r24_b0", 8'h03, 1, 0, 0);
        chk("r24_dst", pkt_dst, 3);
        pkt_ready = 1'b1;
        step();
        beat("r24_b1", 8'h0A, 0, 0, 0);
        step();
        beat("r24_b2", 8'h0B, 0, 1, 0);
        step();
        chk("r24_done", pkt_valid, 0);

        do_reset();
        for (int i = 0; i < 16; i++) send(qb(i));
        chk("r25_ro15", read_out, 1);
        beat("r25_head", qb(0), 1, 0, 0);
        pkt_ready = 1'b1;
        gap();
        chk("r25_no_trunc", {trunc_cnt, runt_cnt}, 0);
        chk("r25_ro_still", read_out, 1);
        for (int i = 1; i < 16; i++) begin
            beat($sformatf("r25_e%0d", i), qb(i), 0, i == 15, 0);
            step();
        end
        chk("r25_drained", pkt_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/switch_rx_port.md
SWITCH_RX_PORT -- requirements
Module: switch_rx_port

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  DATA_W  8  byte-lane width of data_in and pkt_data
  DEPTH  16  FIFO entries; power of two, >= 4
  NUM_PORTS  4  number of switch output ports; valid DA range 0..NUM_PORTS-1
  AF_THRESH  4  read_out asserts when free entries < AF_THRESH
  CNT_W  16  statistics counter width
REQ-002 Ports (name, direction, width, meaning):
  clk  in  1  single clock; all logic on rising edge
  rst_n  in  1  reset; asynchronous, active-low
  data_in  in  DATA_W  serial packet byte, sampled when sw_enable_in=1
  sw_enable_in  in  1  frame: high for every byte of a packet, low between packets
  read_out  out  1  busy; upstream shall not start a packet while high
  pkt_valid  out  1  FIFO head entry valid
  pkt_ready  in  1  consumer accepts head when pkt_valid & pkt_ready
  pkt_data  out  DATA_W  head byte
  pkt_sop  out  1  head is the first byte (DA) of a packet
  pkt_eop  out  1  head is the last stored byte of a packet
  pkt_err  out  1  packet is runt or truncated; valid with pkt_eop
  pkt_dst  out  clog2(NUM_PORTS)  destination port of the packet
  drop_cnt  out  CNT_W  packets discarded entirely
  runt_cnt  out  CNT_W  packets shorter than 3 bytes
  trunc_cnt  out  CNT_W  packets truncated by a full FIFO

Function
REQ-003 Packet format: byte0 = DA, byte1 = SA, then payload; end of packet = first sampled sw_enable_in=0.
REQ-004 FSM states: IDLE, HDR_SA, PAYLOAD, DISCARD.
REQ-005 IDLE + enable=1: DA >= NUM_PORTS, or FIFO free < 2 -> DISCARD, drop_cnt++; otherwise latch DA into the hold register, record dst, set sop, -> HDR_SA.
REQ-006 HDR_SA/PAYLOAD + enable=1: write hold to the FIFO with eop=0, load data_in into hold; HDR_SA -> PAYLOAD.
REQ-007 HDR_SA/PAYLOAD + enable=0: write hold with eop=1, err=1 if packet length < 3 (runt_cnt++), -> IDLE.
REQ-008 Truncation: an eop=0 write with exactly 1 free entry is written as eop=1, err=1; trunc_cnt++; -> DISCARD.
REQ-009 DISCARD: ignore bytes until enable=0 sampled, then -> IDLE; no FIFO writes.
REQ-010 Latency: a byte sampled at edge k is written at edge k+1; if the FIFO was empty, pkt_* present it from edge k+1.
REQ-011 FIFO is first-word-fall-through; pkt_* are stable while pkt_valid=1 and pkt_ready=0.
REQ-012 Simultaneous read and write: occupancy unchanged; write admission (REQ-005/008) uses registered occupancy only.
REQ-013 read_out = (DEPTH - occupancy) < AF_THRESH, registered occupancy.
REQ-014 Counters saturate at all-ones; no wrap.
REQ-015 pkt_valid=0 when the FIFO is empty; reads while empty are ignored.

Reset
REQ-016 rst_n=0 asynchronously: FIFO empty, hold cleared, counters 0, read_out=0, pkt_valid=0, state=DISCARD.
REQ-017 After reset release, bytes are ignored until sw_enable_in=0 is sampled; a packet in flight at reset is never partially stored.

Structure
REQ-018 Package switch_pkg holds the FSM state enum and the parameter default constants.
REQ-019 The FIFO is sub-module switch_sync_fifo (DEPTH, entry width DATA_W+3+clog2(NUM_PORTS)), which exports its occupancy.

Verification
REQ-020 DA=2,SA=5,A1,A2, pkt_ready=1 -> 4 beats 02/05/A1/A2, sop on 02, eop on A2, dst=2, err=0.
REQ-021 DA=1,SA=3, then enable low -> 2 beats, eop on 03 with err=1, runt_cnt=1.
REQ-022 DA=7 (NUM_PORTS=4), 5-byte packet -> no beats, drop_cnt=1, FIFO empty.
REQ-023 pkt_ready=0, 20-byte packet DA=0 -> 16 entries, entry 16 eop=1 err=1, trunc_cnt=1, read_out=1 from occupancy 13; a following packet gives drop_cnt=1.
REQ-024 rst_n pulsed low at byte 3 of a 6-byte packet, enable held high -> no entries stored; next full packet is stored normally.
REQ-025 Read and write in the same cycle at occupancy 15 -> occupancy stays 15, no truncation.
